// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Decode-to-execute operand fetch stage of the RV32I core. It takes decoded
// instruction fields over a valid/ready handshake and drives the register
// file read addresses. A pending-write scoreboard (one bit per architectural
// register, x0 never tracked) holds back instructions with RAW or WAW
// hazards against writes that are still in flight. The resolved operands are
// captured in an output register toward the execute stage.
//
// Optional feature macro: OPFETCH_FORWARD_EN
//   defined   : a source written back in the same cycle is taken from wb_data
//               and the consumer is accepted in that cycle.
//   undefined : no forwarding mux. The consumer waits through the writeback
//               cycle and reads the register file one cycle later.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready is combinational)
//   in_rs1/in_rs2/in_rd  source and destination indices, in_rdwr = writes rd
//   in_imm/in_pc         passed through to the output register
//   ra/rb                register file read addresses (= in_rs1/in_rs2)
//   rf_outa/rf_outb      register file read data (combinational read)
//   wb_valid/wb_rd/
//   wb_data              writeback port, committed to the RF on this edge
//   out_valid/out_ready  downstream handshake
//   out_a/out_b          resolved operands
//   out_rd/out_rdwr/
//   out_imm/out_pc       captured instruction fields
// ---------------------------------------------------------------------------
module operand_fetch #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   input  logic [4:0]      in_rd,
   input  logic            in_rdwr,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pc,
   output logic [4:0]      ra,
   output logic [4:0]      rb,
   input  logic [XLEN-1:0] rf_outa,
   input  logic [XLEN-1:0] rf_outb,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_rdwr,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc
);

   // Scoreboard and output register state
   logic [NREG-1:0] pending_r;
   logic            out_valid_r;
   logic [XLEN-1:0] out_a_r;
   logic [XLEN-1:0] out_b_r;
   logic [4:0]      out_rd_r;
   logic            out_rdwr_r;
   logic [XLEN-1:0] out_imm_r;
   logic [XLEN-1:0] out_pc_r;

   // Combinational control
   logic [NREG-1:0] clr_s;
   logic [NREG-1:0] set_s;
   logic [NREG-1:0] pending_next_s;
   logic            fwd1_s;
   logic            fwd2_s;
   logic            haz1_s;
   logic            haz2_s;
   logic            hazw_s;
   logic            in_ready_s;
   logic            accept_s;
   logic [XLEN-1:0] opa_s;
   logic [XLEN-1:0] opb_s;

   // Returns vec[idx]; entries at or beyond NREG, and entry 0, read as 0 so
   // a narrow scoreboard never indexes out of range.
   function automatic logic bit_at(input logic [NREG-1:0] vec,
                                   input logic [4:0]      idx);
      logic hit;
      hit = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         hit = hit | (vec[r] & (idx == 5'(r)));
      end
      return hit;
   endfunction

   // Register file read addresses follow the decoded sources directly
   always_comb begin
      ra = in_rs1;
      rb = in_rs2;
   end

   // Writeback clear vector; x0 is never tracked
   always_comb begin
      clr_s = {NREG{1'b0}};
      for (int r = 1; r < NREG; r++) begin
         clr_s[r] = wb_valid && (wb_rd == 5'(r));
      end
   end

`ifdef OPFETCH_FORWARD_EN
   // Same-cycle writeback match and the operand forwarding mux
   always_comb begin
      fwd1_s = wb_valid && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
      fwd2_s = wb_valid && (wb_rd == in_rs2) && (in_rs2 != 5'd0);
      if (fwd1_s) begin
         opa_s = wb_data;
      end else begin
         opa_s = rf_outa;
      end
      if (fwd2_s) begin
         opb_s = wb_data;
      end else begin
         opb_s = rf_outb;
      end
   end
`else
   // Without forwarding, wb_data only reaches operands via the register file
   logic unused_wb_data_s;

   // Operands come straight from the register file
   always_comb begin
      fwd1_s           = 1'b0;
      fwd2_s           = 1'b0;
      opa_s            = rf_outa;
      opb_s            = rf_outb;
      unused_wb_data_s = ^wb_data;
   end
`endif

   // Hazard detection and the upstream ready. A WAW is released by a
   // writeback to the same register in this cycle because the new set
   // overrides that clear in the scoreboard update.
   always_comb begin
      haz1_s     = bit_at(pending_r, in_rs1) && !fwd1_s;
      haz2_s     = bit_at(pending_r, in_rs2) && !fwd2_s;
      hazw_s     = in_rdwr && bit_at(pending_r, in_rd) && !bit_at(clr_s, in_rd);
      in_ready_s = !rst && (!out_valid_r || out_ready)
                   && !haz1_s && !haz2_s && !hazw_s;
      accept_s   = in_valid && in_ready_s;
      in_ready   = in_ready_s;
   end

   // Scoreboard set vector for an accepted writer; rd = x0 sets nothing
   always_comb begin
      set_s = {NREG{1'b0}};
      for (int r = 1; r < NREG; r++) begin
         set_s[r] = accept_s && in_rdwr && (in_rd == 5'(r));
      end
   end

   // Scoreboard next state: set has priority over a same-cycle clear
   always_comb begin
      pending_next_s = (pending_r & ~clr_s) | set_s;
   end

   // Scoreboard register; bit 0 is forced low
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= {NREG{1'b0}};
      end else begin
         pending_r <= {pending_next_s[NREG-1:1], 1'b0};
      end
   end

   // Output register: load on accept, drain on out_ready, otherwise hold.
   // Held operands deliberately ignore later writebacks.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_a_r     <= {XLEN{1'b0}};
         out_b_r     <= {XLEN{1'b0}};
         out_rd_r    <= 5'd0;
         out_rdwr_r  <= 1'b0;
         out_imm_r   <= {XLEN{1'b0}};
         out_pc_r    <= {XLEN{1'b0}};
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_a_r     <= opa_s;
         out_b_r     <= opb_s;
         out_rd_r    <= in_rd;
         out_rdwr_r  <= in_rdwr;
         out_imm_r   <= in_imm;
         out_pc_r    <= in_pc;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Registered outputs toward execute
   always_comb begin
      out_valid = out_valid_r;
      out_a     = out_a_r;
      out_b     = out_b_r;
      out_rd    = out_rd_r;
      out_rdwr  = out_rdwr_r;
      out_imm   = out_imm_r;
      out_pc    = out_pc_r;
   end

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//
// Self-checking bench for operand_fetch. The bench owns a register file
// array and a reference model kept as a set of pending registers plus a
// copy of the instruction sitting in the output stage. Directed scenarios
// are followed by a randomized phase; every comparison goes through check_eq.
// Builds with or without OPFETCH_FORWARD_EN.
// ---------------------------------------------------------------------------
module tb_operand_fetch;

   localparam int XLEN = 32;
`ifdef OPFETCH_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      in_rs1, in_rs2, in_rd;
   logic            in_rdwr;
   logic [XLEN-1:0] in_imm, in_pc;
   logic [4:0]      ra, rb;
   logic [XLEN-1:0] rf_outa, rf_outb;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_a, out_b;
   logic [4:0]      out_rd;
   logic            out_rdwr;
   logic [XLEN-1:0] out_imm, out_pc;

   always #5 clk = ~clk;

   operand_fetch #(.XLEN(XLEN), .NREG(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rdwr(in_rdwr),
      .in_imm(in_imm), .in_pc(in_pc),
      .ra(ra), .rb(rb), .rf_outa(rf_outa), .rf_outb(rf_outb),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_rdwr(out_rdwr),
      .out_imm(out_imm), .out_pc(out_pc)
   );

   // Bench-side register file, x0 reads 0
   logic [XLEN-1:0] rf [32];
   assign rf_outa = (ra == 5'd0) ? 32'd0 : rf[ra];
   assign rf_outb = (rb == 5'd0) ? 32'd0 : rf[rb];

   // Reference model
   logic [31:0]     m_pend;
   bit              m_ov;
   logic [XLEN-1:0] m_a, m_b, m_imm, m_pc;
   logic [4:0]      m_rd;
   bit              m_rdwr;
   bit              g_dacc;      // DUT handshake fired on the last step

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Architectural value a source sees at accept time
   function automatic logic [31:0] src_val(input logic [4:0] rs, input bit fwd);
      if (rs == 5'd0) return 32'd0;
      if (fwd) return wb_data;
      return rf[rs];
   endfunction

   // One clock: check combinational outputs mid-cycle, advance model and RF
   // across the edge, then check the registered outputs.
   task automatic step();
      bit f1, f2, cw, rdy, acc;
      logic [31:0] na, nb;
      #4;
      f1  = FWD && wb_valid && wb_rd == in_rs1 && in_rs1 != 5'd0;
      f2  = FWD && wb_valid && wb_rd == in_rs2 && in_rs2 != 5'd0;
      cw  = wb_valid && wb_rd == in_rd && in_rd != 5'd0;
      rdy = !rst && (!m_ov || out_ready)
            && !(m_pend[in_rs1] && !f1) && !(m_pend[in_rs2] && !f2)
            && !(in_rdwr && m_pend[in_rd] && !cw);
      check_eq("in_ready", in_ready, rdy);
      check_eq("ra", ra, in_rs1);
      check_eq("rb", rb, in_rs2);
      g_dacc = in_valid && in_ready;
      acc = in_valid && rdy;
      na  = src_val(in_rs1, f1);
      nb  = src_val(in_rs2, f2);
      @(posedge clk);
      #1;
      if (rst) begin
         m_pend = 32'd0; m_ov = 1'b0; m_a = 32'd0; m_b = 32'd0;
         m_imm = 32'd0; m_pc = 32'd0; m_rd = 5'd0; m_rdwr = 1'b0;
      end else begin
         if (wb_valid && wb_rd != 5'd0) m_pend[wb_rd] = 1'b0;
         if (acc) begin
            if (in_rdwr && in_rd != 5'd0) m_pend[in_rd] = 1'b1;
            m_ov = 1'b1; m_a = na; m_b = nb; m_imm = in_imm; m_pc = in_pc;
            m_rd = in_rd; m_rdwr = in_rdwr;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
      end
      if (wb_valid && wb_rd != 5'd0) rf[wb_rd] = wb_data;
      check_eq("out_valid", out_valid, m_ov);
      check_eq("out_a", out_a, m_a);
      check_eq("out_b", out_b, m_b);
      check_eq("out_rd", out_rd, m_rd);
      check_eq("out_rdwr", out_rdwr, m_rdwr);
      check_eq("out_imm", out_imm, m_imm);
      check_eq("out_pc", out_pc, m_pc);
      check_eq("pending", dut.pending_r, m_pend);
   endtask

   task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rdwr);
      in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rdwr = rdwr;
      in_imm = $urandom; in_pc = $urandom;
      g_dacc = 1'b0;
   endtask

   task automatic wait_accept(input string tag, input int budget);
      int n;
      n = 0;
      while (!g_dacc && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, g_dacc, 1'b1);
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rdwr);
      drive_instr(rs1, rs2, rd, rdwr);
      wait_accept("issue_accept", 20);
      in_valid = 1'b0;
   endtask

   task automatic wb_step(input logic [4:0] rd, input logic [31:0] data);
      wb_valid = 1'b1; wb_rd = rd; wb_data = data;
      step();
      wb_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held_a;
      logic [4:0]  r;
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
      m_pend = 32'd0; m_ov = 1'b0; m_a = 32'd0; m_b = 32'd0;
      m_imm = 32'd0; m_pc = 32'd0; m_rd = 5'd0; m_rdwr = 1'b0;
      g_dacc = 1'b0;
      wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      // Reset cycles with an instruction offered: in_ready must stay low
      drive_instr(5'd1, 5'd2, 5'd3, 1'b1);
      step();
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_pending", dut.pending_r, 32'd0);

      // Writer of x5, then a stalled consumer
      issue(5'd1, 5'd2, 5'd5, 1'b1);
      drive_instr(5'd5, 5'd0, 5'd9, 1'b0);
      repeat (10) step();
      check_eq("x5_stall_ready", in_ready, 1'b0);
      check_eq("x5_pending", dut.pending_r[5], 1'b1);
      wb_step(5'd5, 32'h0000_00AB);
      check_eq("wb5_accept", g_dacc, FWD);
      if (!FWD) begin
         step();
         check_eq("wb5_late_accept", g_dacc, 1'b1);
      end
      in_valid = 1'b0;
      check_eq("x5_out_a", out_a, 32'h0000_00AB);

      // New writer of x7 in the same cycle a writeback clears x7
      issue(5'd0, 5'd0, 5'd7, 1'b1);
      drive_instr(5'd1, 5'd2, 5'd7, 1'b1);
      wb_step(5'd7, $urandom);
      check_eq("x7_waw_accept", g_dacc, 1'b1);
      in_valid = 1'b0;
      check_eq("x7_set_wins", dut.pending_r[7], 1'b1);
      drive_instr(5'd7, 5'd0, 5'd0, 1'b0);
      repeat (3) step();
      check_eq("x7_reader_stall", in_ready, 1'b0);
      wb_step(5'd7, 32'h0000_7777);
      if (!g_dacc) wait_accept("x7_reader_accept", 5);
      in_valid = 1'b0;
      check_eq("x7_reader_a", out_a, 32'h0000_7777);

      // x0 source and destination with a writeback to x0
      drive_instr(5'd0, 5'd0, 5'd0, 1'b1);
      wb_step(5'd0, 32'hFFFF_FFFF);
      check_eq("x0_no_stall", g_dacc, 1'b1);
      in_valid = 1'b0;
      check_eq("x0_out_a", out_a, 32'd0);
      check_eq("x0_pending", dut.pending_r, 32'd0);

      // Downstream backpressure: held output ignores later writebacks
      issue(5'd3, 5'd4, 5'd6, 1'b1);
      held_a = m_a;
      out_ready = 1'b0;
      drive_instr(5'd1, 5'd2, 5'd8, 1'b0);
      wb_step(5'd3, 32'h1234_5678);
      repeat (4) step();
      check_eq("hold_ready", in_ready, 1'b0);
      check_eq("hold_out_a", out_a, held_a);
      out_ready = 1'b1;
      wait_accept("hold_release", 5);
      in_valid = 1'b0;
      wb_step(5'd6, $urandom);

      // Reset with three pending writers and a held instruction
      issue(5'd0, 5'd0, 5'd10, 1'b1);
      issue(5'd0, 5'd0, 5'd11, 1'b1);
      issue(5'd0, 5'd0, 5'd12, 1'b1);
      check_eq("pre_rst_pending", dut.pending_r, 32'h0000_1C00);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("post_rst_pending", dut.pending_r, 32'd0);
      check_eq("post_rst_valid", out_valid, 1'b0);
      drive_instr(5'd10, 5'd11, 5'd0, 1'b0);
      wb_step(5'd12, $urandom);
      check_eq("post_rst_reader", g_dacc, 1'b1);
      in_valid = 1'b0;
      check_eq("post_rst_wb_pending", dut.pending_r, 32'd0);

      // Randomized traffic over registers x0..x7 to provoke hazards
      for (int c = 0; c < 1500; c++) begin
         if (!in_valid || g_dacc) begin
            if ($urandom_range(0, 3) != 0)
               drive_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            else
               in_valid = 1'b0;
         end
         wb_valid = 1'($urandom_range(0, 1));
         wb_data  = $urandom;
         wb_rd    = 5'($urandom_range(0, 7));
         for (int t = 0; t < 8; t++) begin
            r = 5'($urandom_range(1, 7));
            if (m_pend[r]) begin
               wb_rd = r;
               break;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      wb_valid = 1'b0;
      in_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute operand fetch stage of the RV32I core. Accepts decoded instruction fields over a valid/ready handshake and drives the register file read addresses. It resolves RAW/WAW hazards against in-flight writes with a 32-entry pending-write scoreboard and forwards same-cycle writeback data. Operands are registered toward the execute stage.

## Interface
Parameters:
- XLEN, 32, data width of operands, immediate and PC.
- NREG, 32, architectural register count; scoreboard width. Register 0 is never tracked.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs1, in_rs2  in  5  source register indices.
- in_rd  in  5  destination index.
- in_rdwr  in  1  instruction writes in_rd.
- in_imm, in_pc  in  XLEN  immediate and PC, passed through.
- ra, rb  out  5  register file read addresses; combinationally equal to in_rs1 and in_rs2.
- rf_outa, rf_outb  in  XLEN  register file read data (combinational read).
- wb_valid  in  1  writeback this cycle; the same wb_rd/wb_data are written into the register file on this edge.
- wb_rd  in  5  writeback index.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  registered instruction available to execute.
- out_ready  in  1  execute accepts.
- out_a, out_b  out  XLEN  resolved operands.
- out_rd  out  5  destination index.
- out_rdwr  out  1  destination write flag.
- out_imm, out_pc  out  XLEN  passed through.

## Operation
- pending[NREG-1:0] scoreboard: bit r set means a write to r is issued and not yet written back. Bit 0 is hard-wired 0.
- clr[r] = wb_valid && wb_rd==r && r!=0.
- Forward match fwd1 = FWD_EN && wb_valid && wb_rd==in_rs1 && in_rs1!=0. fwd2 is the same check against in_rs2.
- Hazard terms:
  - haz1 = pending[in_rs1] && !fwd1.
  - haz2 = pending[in_rs2] && !fwd2.
  - hazw = in_rdwr && pending[in_rd] && !clr[in_rd] (WAW).
- in_ready = (!out_valid || out_ready) && !haz1 && !haz2 && !hazw.
- Accept = in_valid && in_ready. On accept:
  - out_a = fwd1 ? wb_data : rf_outa. out_b uses fwd2 and rf_outb the same way.
  - out_rd, out_rdwr, out_imm, out_pc are captured.
  - out_valid is set to 1.
- out_valid clears on out_ready when there is no accept in the same cycle.
- Operands held in the output register are not updated by later writebacks.
- Scoreboard next state:
  - pending[r] = (pending[r] && !clr[r]) || set[r].
  - set[r] = accept && in_rdwr && in_rd==r && r!=0.
  - Set and clear of the same r in one cycle: set wins.
- Any index 0 source reads 0 from the register file. It is never pending and never forwarded.
- in_rdwr with in_rd==0 sets nothing.
- A writeback with wb_rd whose pending bit is already clear is harmless. The bit stays clear.

## Timing
- Reset values:
  - out_valid = 0.
  - pending = 0.
  - out_a, out_b, out_imm, out_pc = 0.
  - out_rd = 0, out_rdwr = 0.
- in_ready is forced 0 during the reset cycle.
- Reset mid-operation discards the held instruction and all pending bits. Downstream writebacks after reset do not re-set any bits.
- Latency: accept at edge N gives out_valid=1 after edge N.
- Throughput: one per cycle when there are no hazards and out_ready is held 1.
- in_ready depends combinationally on in_* and wb_*. in_valid must not depend on in_ready.
- Upstream holds in_* stable while in_valid && !in_ready.
- Downstream may hold out_ready=0 indefinitely. out_* are stable while out_valid && !out_ready.

## Configuration
- OPFETCH_FORWARD_EN defined: FWD_EN=1.
  - A consumer whose source is written back in the same cycle is accepted that cycle with wb_data.
- Undefined: FWD_EN=0. No forwarding mux is built.
  - A consumer of a pending register stalls through the writeback cycle.
  - It is accepted the next cycle, reading the register file (one extra bubble).
- WAW handling is identical in both builds.

## Test plan
- Reset, then issue add x5 (rdwr, rd=5), then a consumer with rs1=5 and no writeback: pending[5]=1 and in_ready=0; the consumer stays stalled for 10 cycles.
- wb_valid, wb_rd=5, wb_data=0x0000_00AB while the consumer waits:
  - With OPFETCH_FORWARD_EN: accepted that cycle, out_a=0x0000_00AB.
  - Without it: accepted one cycle later, out_a=rf_outa=0x0000_00AB.
- Issue a new writer of x7 in the same cycle that wb clears x7: pending[7]=1 afterwards (set wins). A following reader of x7 stalls.
- rs1=0, rd=0, rdwr=1 with wb_rd=0, wb_data=0xFFFF_FFFF: out_a=0, no stall, pending stays 0.
- Hold out_ready=0 with out_valid=1 for 5 cycles: in_ready=0 and out_* are unchanged. A wb to the held instruction's source does not alter out_a.
- Assert rst with 3 pending bits set and out_valid=1: the next cycle has pending=0 and out_valid=0. A reader of those registers is accepted immediately.
